// File: rtl/vae_sequencer.sv
`timescale 1ns/1ps
// vae_sequencer: loads one frame (pixels + epsilon), streams it to the encoder,
// waits for the decoder, then drains the result BRAM through a 3-entry FIFO.
// Define VAE_SEQ_TIMEOUT_EN to add a WAIT_DEC watchdog of TIMEOUT cycles.
module vae_sequencer #(
  parameter int PIXELS  = 784,
  parameter int EPS_N   = 2,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic [9:0]  pix_addr,
  output logic        pix_we,
  output logic [19:0] pix_din,
  output logic [1:0]  eps_addr,
  output logic        eps_we,
  output logic [11:0] eps_din,
  output logic        enc_valid,
  input  logic        dec_done,
  output logic [9:0]  res_addr,
  input  logic [19:0] res_dout,
  output logic [19:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  localparam int CW = 16;
  localparam logic [CW-1:0] PIX_N    = CW'(PIXELS);
  localparam logic [CW-1:0] PIX_END  = CW'(PIXELS - 1);
  localparam logic [CW-1:0] EPS_END  = CW'(EPS_N - 1);
  localparam logic [CW-1:0] LAT      = CW'(RD_LAT);
  localparam logic [CW-1:0] FEED_END = CW'(PIXELS + RD_LAT - 1);

  if (!(PIXELS >= 1 && PIXELS <= 1024 && EPS_N >= 1 && EPS_N <= 4 &&
        RD_LAT >= 1 && TIMEOUT >= 1)) begin : g_cfg_check
    $error("vae_sequencer: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD_PIX, LOAD_EPS, FEED_ENC, WAIT_DEC, SEND, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     iss_q, iss_d;
  logic [CW-1:0]     pop_q, pop_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [19:0]       fifo_q [3];
  logic [1:0]        wr_q, rd_q, occ_q;
  logic [3:0]        pending;
  logic              issue, push, pop, tmo_hit;

  // Reads in flight count against FIFO space so back-pressure never drops data.
  always_comb begin
    pending = {2'b00, occ_q};
    for (int i = 0; i < RD_LAT; i++) pending = pending + {3'b000, pipe_q[i]};
  end

  assign issue     = (state_q == SEND) && (iss_q < PIX_N) && (pending < 4'd3);
  assign pipe_d    = (pipe_q << 1) | RD_LAT'(issue);
  assign push      = pipe_q[RD_LAT-1];
  assign out_valid = (occ_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_q[rd_q] : '0;
  assign out_last  = out_valid && (pop_q == PIX_END);
  assign busy      = (state_q != IDLE);
  assign err       = (state_q == ERR);

`ifdef VAE_SEQ_TIMEOUT_EN
  localparam logic [31:0] TMO_END = 32'(TIMEOUT - 1);
  logic [31:0] tmo_q, tmo_d;

  assign tmo_d   = (state_q == WAIT_DEC) ? tmo_q + 32'd1 : '0;
  assign tmo_hit = (state_q == WAIT_DEC) && (tmo_q == TMO_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iss_d     = iss_q + CW'(issue);
    pop_d     = pop_q + CW'(pop);
    in_ready  = 1'b0;
    pix_addr  = '0;
    pix_we    = 1'b0;
    pix_din   = '0;
    eps_addr  = '0;
    eps_we    = 1'b0;
    eps_din   = '0;
    enc_valid = 1'b0;
    res_addr  = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid) state_d = LOAD_PIX;
      end
      LOAD_PIX: begin
        in_ready = 1'b1;
        pix_addr = cnt_q[9:0];
        pix_din  = in_data;
        if (in_valid) begin
          pix_we = 1'b1;
          if (in_last) begin
            state_d = ERR;
          end else if (cnt_q == PIX_END) begin
            state_d = LOAD_EPS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_EPS: begin
        in_ready = 1'b1;
        eps_addr = cnt_q[1:0];
        eps_din  = in_data[11:0];
        if (in_valid) begin
          eps_we = 1'b1;
          if (cnt_q == EPS_END) begin
            state_d = in_last ? FEED_ENC : ERR;
            cnt_d   = '0;
          end else if (in_last) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FEED_ENC: begin
        // Counter runs RD_LAT cycles past the last address so enc_valid trails it.
        if (cnt_q < PIX_N) pix_addr = cnt_q[9:0];
        enc_valid = (cnt_q >= LAT);
        if (cnt_q == FEED_END) begin
          state_d = WAIT_DEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DEC: begin
        if (dec_done)     state_d = SEND;
        else if (tmo_hit) state_d = ERR;
      end
      SEND: begin
        if (iss_q < PIX_N) res_addr = iss_q[9:0];
        if (pop && (pop_q == PIX_END)) begin
          state_d = IDLE;
          iss_d   = '0;
          pop_d   = '0;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      iss_q   <= '0;
      pop_q   <= '0;
      pipe_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      for (int i = 0; i < 3; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      pop_q   <= pop_d;
      pipe_q  <= pipe_d;
      if (push) begin
        fifo_q[wr_q] <= res_dout;
        wr_q         <= (wr_q == 2'd2) ? 2'd0 : wr_q + 2'd1;
      end
      if (pop) rd_q <= (rd_q == 2'd2) ? 2'd0 : rd_q + 2'd1;
      occ_q <= occ_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_vae_sequencer.sv
`timescale 1ns/1ps
// tb_vae_sequencer: directed frames with a queue scoreboard on the output stream
// and a write monitor on the pixel/epsilon BRAM ports.
module tb_vae_sequencer;

  localparam int PIXELS  = 784;
  localparam int EPS_N   = 2;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic        in_ready;
  logic [9:0]  pix_addr;
  logic        pix_we;
  logic [19:0] pix_din;
  logic [1:0]  eps_addr;
  logic        eps_we;
  logic [11:0] eps_din;
  logic        enc_valid;
  logic        dec_done = 1'b0;
  logic [9:0]  res_addr;
  logic [19:0] res_dout;
  logic [19:0] out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;
  logic        busy, err;

  always #5 clk = ~clk;

  vae_sequencer #(.PIXELS(PIXELS), .EPS_N(EPS_N), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .pix_addr(pix_addr), .pix_we(pix_we), .pix_din(pix_din),
    .eps_addr(eps_addr), .eps_we(eps_we), .eps_din(eps_din),
    .enc_valid(enc_valid), .dec_done(dec_done),
    .res_addr(res_addr), .res_dout(res_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .err(err)
  );

  typedef struct packed { logic [19:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int salt = 0, res_salt = 0;
  int wr_seen = 0, eps_seen = 0;
  logic [19:0] r1, r2;

  function automatic logic [19:0] beat_val(input int b, input int s);
    return 20'(b * 97 + s * 7919 + 3);
  endfunction

  function automatic logic [19:0] res_val(input int a, input int s);
    return 20'(a * 37 + s * 5003 + 11);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Result BRAM model with RD_LAT = 2 registered read.
  always @(posedge clk) begin
    r1 <= res_val(int'(res_addr), res_salt);
    r2 <= r1;
  end
  assign res_dout = r2;

  initial forever begin : write_mon
    logic [19:0] bv;
    @(negedge clk);
    if (!busy) begin
      wr_seen  = 0;
      eps_seen = 0;
    end else begin
      if (pix_we) begin
        chk("pix_addr", 32'(pix_addr), 32'(wr_seen));
        chk("pix_din", 32'(pix_din), 32'(beat_val(wr_seen, salt)));
        wr_seen++;
      end
      if (eps_we) begin
        bv = beat_val(PIXELS + eps_seen, salt);
        chk("eps_addr", 32'(eps_addr), 32'(eps_seen));
        chk("eps_din", 32'(eps_din), 32'(bv[11:0]));
        eps_seen++;
      end
    end
  end

  initial forever begin : out_mon
    exp_t e;
    @(negedge clk);
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_extra: got beat %0h, required no beat", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_last", 32'(out_last), 32'(e.l));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; dec_done = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic send_frame(input int n, input int last_at);
    int waited;
    for (int b = 0; b < n; b++) begin
      in_data = beat_val(b, salt); in_last = (b == last_at); in_valid = 1'b1;
      waited = 0;
      do begin @(negedge clk); waited++; end while (!in_ready && waited < 20);
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL load_stall: in_ready low for 20 cycles at beat %0d", b);
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Starts in FEED_ENC cycle 0; leaves at cycle PIXELS+9 (already in WAIT_DEC).
  task automatic check_feed();
    int first = -1, cnt = 0, gaps = 0, addr_bad = 0;
    logic prev = 1'b0;
    for (int k = 0; k < PIXELS + 10; k++) begin
      @(negedge clk);
      if (k < PIXELS && (pix_addr != 10'(k) || pix_we)) addr_bad++;
      if (enc_valid) begin
        if (first < 0) first = k;
        else if (!prev) gaps++;
        cnt++;
      end
      prev = enc_valid;
    end
    chk("feed_addr_errors", 32'(addr_bad), 0);
    chk("enc_first_cycle", 32'(first), 32'(RD_LAT));
    chk("enc_count", 32'(cnt), 32'(PIXELS));
    chk("enc_gaps", 32'(gaps), 0);
    chk("wait_in_ready", 32'(in_ready), 0);
    chk("wait_busy", 32'(busy), 1);
  endtask

  task automatic run_results(input int mode);
    int cyc;
    for (int i = 0; i < PIXELS; i++) exp_q.push_back({res_val(i, res_salt), (i == PIXELS - 1)});
    @(posedge clk); #1;
    dec_done = 1'b1; out_ready = (mode == 0);
    @(posedge clk); #1;
    dec_done = 1'b0;
    for (cyc = 1; cyc < 10000; cyc++) begin
      out_ready = (mode == 0) || (cyc % 3 == 0);
      @(posedge clk);
      if (exp_q.size() == 0) break;
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    @(negedge clk);
    chk("busy_after_last", 32'(busy), 0);
    chk("out_valid_after_last", 32'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  task automatic good_frame(input int s, input int mode);
    salt = s; res_salt = s + 100;
    send_frame(PIXELS + EPS_N, PIXELS + EPS_N - 1);
    chk("pix_writes", 32'(wr_seen), 32'(PIXELS));
    chk("eps_writes", 32'(eps_seen), 32'(EPS_N));
    check_feed();
    run_results(mode);
    $display("frame salt=%0d ready_mode=%0d done, checks=%0d errors=%0d", s, mode, checks, errors);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with active inputs driven.
    in_valid = 1'b1; in_data = 20'hABCDE; dec_done = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({in_ready, pix_we, eps_we, enc_valid, out_valid, out_last, busy, err}), 0);
    chk("rst_addr", 32'({pix_addr, eps_addr, res_addr}), 0);
    chk("rst_pix_din", 32'(pix_din), 0);
    chk("rst_eps_out", 32'({eps_din, out_data}), 0);
    in_valid = 1'b0; dec_done = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    good_frame(1, 0);
    good_frame(2, 1);

    // Early in_last on beat 100.
    salt = 5;
    send_frame(101, 100);
    @(negedge clk);
    chk("early_err", 32'(err), 1);
    chk("early_in_ready", 32'(in_ready), 0);
    chk("early_writes", 32'(wr_seen), 101);
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("err_hold", 32'(err), 1);
    chk("err_no_accept", 32'(wr_seen), 101);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_clears_err", 32'(err), 0);
    chk("rst_idle", 32'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", 32'(busy), 0);
    $display("frame early-last: err raised and cleared by reset");

    // Missing in_last on the final epsilon beat.
    salt = 6;
    send_frame(PIXELS + EPS_N, -1);
    @(negedge clk);
    chk("nolast_err", 32'(err), 1);
    chk("nolast_eps_writes", 32'(eps_seen), 32'(EPS_N));
    do_reset();
    $display("frame missing-last: err raised");

    // Abandon a frame at beat 400, then a fresh frame.
    salt = 7;
    send_frame(400, -1);
    chk("partial_writes", 32'(wr_seen), 400);
    do_reset();
    good_frame(8, 0);

`ifdef VAE_SEQ_TIMEOUT_EN
    begin : timeout_test
      int first_k = -1;
      salt = 9;
      send_frame(PIXELS + EPS_N, PIXELS + EPS_N - 1);
      check_feed();
      for (int k = PIXELS + 10; k < PIXELS + RD_LAT + TIMEOUT + 5; k++) begin
        @(negedge clk);
        if (err && first_k < 0) first_k = k;
      end
      chk("timeout_cycles", 32'(first_k - (PIXELS + RD_LAT)), 32'(TIMEOUT));
      do_reset();
      $display("frame timeout: err after %0d cycles", first_k - (PIXELS + RD_LAT));
    end
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vae_sequencer.md
VAE_SEQUENCER -- requirements
Module: vae_sequencer

Interface
REQ-001 SHALL have parameter PIXELS, default 784, giving the pixel words per frame.
REQ-002 SHALL have parameter EPS_N, default 2, giving the epsilon words per frame, sent after the pixels.
REQ-003 SHALL have parameter RD_LAT, default 2, giving the BRAM read latency in cycles.
REQ-004 SHALL have parameter TIMEOUT, default 200000, giving the maximum cycles to wait for the decoder.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports in_data (input, 20), in_valid (input, 1), in_ready (output, 1), in_last (input, 1): the input stream.
REQ-008 SHALL have ports pix_addr (output, 10), pix_we (output, 1), pix_din (output, 20): the pixel BRAM port.
REQ-009 SHALL have ports eps_addr (output, 2), eps_we (output, 1), eps_din (output, 12): the epsilon BRAM port; eps_din = in_data[11:0].
REQ-010 SHALL have ports enc_valid (output, 1) and dec_done (input, 1): the encoder feed strobe and the decoder completion level.
REQ-011 SHALL have ports res_addr (output, 10) and res_dout (input, 20): the result BRAM read port.
REQ-012 SHALL have ports out_data (output, 20), out_valid (output, 1), out_ready (input, 1), out_last (output, 1): the output stream.
REQ-013 SHALL have ports busy (output, 1) and err (output, 1): status.

Function
REQ-014 SHALL implement states IDLE, LOAD_PIX, LOAD_EPS, FEED_ENC, WAIT_DEC, SEND and ERR.
REQ-015 SHALL move IDLE to LOAD_PIX on the first in_valid; busy=0 only in IDLE.
REQ-016 In LOAD_PIX, in_ready SHALL be 1; each in_valid&in_ready beat writes pix_addr = beat index, starting at 0, with pix_we=1 in that cycle.
REQ-017 After pixel beat PIXELS-1, SHALL enter LOAD_EPS and write EPS_N beats to eps_addr 0..EPS_N-1.
REQ-018 SHALL enter FEED_ENC after the final epsilon beat.
REQ-019 SHALL enter ERR if in_last arrives before the final epsilon beat or is absent on it; in_ready SHALL be 0 in ERR.
REQ-020 In FEED_ENC, SHALL drive pix_addr 0..PIXELS-1 on consecutive cycles with pix_we=0.
REQ-021 SHALL assert enc_valid exactly RD_LAT cycles after each FEED_ENC address, giving PIXELS contiguous cycles.
REQ-022 SHALL enter WAIT_DEC on the cycle after the last enc_valid.
REQ-023 In WAIT_DEC, SHALL enter SEND on the first cycle dec_done=1.
REQ-024 In SEND, SHALL issue res_addr 0..PIXELS-1 in order and capture res_dout RD_LAT cycles after each issue into a 3-entry output FIFO.
REQ-025 SHALL issue a new res_addr only when FIFO occupancy plus reads in flight is less than 3, so no data is lost under back-pressure.
REQ-026 out_valid SHALL equal FIFO not-empty; a beat transfers when out_valid&out_ready.
REQ-027 out_last SHALL be 1 on the beat carrying address PIXELS-1 only.
REQ-028 SHALL return to IDLE the cycle after the last beat transfers.
REQ-029 Simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-030 in_ready SHALL be 0 in all states other than LOAD_PIX and LOAD_EPS.
REQ-031 dec_done SHALL be ignored outside WAIT_DEC.
REQ-032 ERR SHALL set err=1 and hold until reset.

Reset
REQ-033 reset=0 SHALL immediately force state to IDLE, clear all counters and the FIFO, and drive in_ready, pix_we, eps_we, enc_valid, out_valid, out_last, busy, err = 0 and all address and data outputs = 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; the next frame restarts at pixel address 0.

Configuration
REQ-035 With VAE_SEQ_TIMEOUT_EN defined, a TIMEOUT-cycle counter SHALL run in WAIT_DEC and enter ERR when it reaches TIMEOUT without dec_done.
REQ-036 Without VAE_SEQ_TIMEOUT_EN, no counter SHALL be built and WAIT_DEC SHALL wait indefinitely.

Verification
REQ-037 Stream 786 beats with in_last on beat 785 -> pix_we asserted for addresses 0..783; eps_we asserted for addresses 0 and 1; then enc_valid high for exactly 784 contiguous cycles, beginning 2 cycles after pix_addr=0.
REQ-038 Assert dec_done with out_ready held at 1 -> 784 output beats with data equal to the result BRAM contents in order; out_last set only on beat 784; busy falls the following cycle.
REQ-039 Drive out_ready as a 1-of-3 pattern during SEND -> no lost or duplicated words, and FIFO occupancy never exceeds 3.
REQ-040 Send in_last on beat 100 -> err=1, in_ready=0; then pulse reset low -> err=0 and state is IDLE.
REQ-041 With VAE_SEQ_TIMEOUT_EN and TIMEOUT=50, never assert dec_done -> err=1 exactly 50 cycles after WAIT_DEC is entered.
REQ-042 Drop reset at beat 400 of LOAD_PIX, then send a fresh frame -> writes restart at pixel address 0 and the output is correct.
